// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB forwarding, load-use bubble insertion and ALU operand select.
// One cycle ID->EX; operands are combinational from EX registers and forwarding inputs; id_ready drops on load-use or ex_stall.
module ex_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1_idx,
    input  logic [4:0]      id_rs2_idx,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_a_sel_pc,
    input  logic            id_b_sel_imm,
    input  logic [4:0]      id_alu_op,
    input  logic [4:0]      id_rd_idx,
    input  logic            id_reg_we,
    input  logic            id_mem_read,
    input  logic            flush,
    input  logic            ex_stall,
    input  logic [4:0]      mem_rd_idx,
    input  logic            mem_reg_we,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic [4:0]      wb_rd_idx,
    input  logic            wb_reg_we,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      alu_op,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd_idx,
    output logic            ex_reg_we,
    output logic            ex_mem_read
);

    localparam logic [4:0] ALU_ADD = 5'd0;

    logic            valid_q,     valid_d;
    logic [XLEN-1:0] pc_q,        pc_d;
    logic [4:0]      rs1_idx_q,   rs1_idx_d;
    logic [4:0]      rs2_idx_q,   rs2_idx_d;
    logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
    logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
    logic [XLEN-1:0] imm_q,       imm_d;
    logic            a_sel_pc_q,  a_sel_pc_d;
    logic            b_sel_imm_q, b_sel_imm_d;
    logic [4:0]      alu_op_q,    alu_op_d;
    logic [4:0]      rd_idx_q,    rd_idx_d;
    logic            reg_we_q,    reg_we_d;
    logic            mem_read_q,  mem_read_d;

    logic            hz;
    logic            rs1_hit;
    logic            rs2_hit;
    logic            bubble;
    logic [XLEN-1:0] cap_rs1;
    logic [XLEN-1:0] cap_rs2;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // Load-use: the load in EX has no data yet, so the dependent instruction must wait one cycle in ID.
    always_comb begin
        rs1_hit  = id_rs1_used && (id_rs1_idx == rd_idx_q);
        rs2_hit  = id_rs2_used && (id_rs2_idx == rd_idx_q);
        hz       = ex_mem_read && (rd_idx_q != 5'd0) && id_valid && (rs1_hit || rs2_hit);
        id_ready = !ex_stall && !hz;
        bubble   = flush || hz || !id_valid;
    end

    // The register file writes and reads in the same cycle, so WB data must be taken over stale read data.
    always_comb begin
        cap_rs1 = id_rs1_data;
        cap_rs2 = id_rs2_data;
        if (wb_reg_we && (wb_rd_idx != 5'd0) && (wb_rd_idx == id_rs1_idx)) begin
            cap_rs1 = wb_data;
        end
        if (wb_reg_we && (wb_rd_idx != 5'd0) && (wb_rd_idx == id_rs2_idx)) begin
            cap_rs2 = wb_data;
        end
    end

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_idx_d   = rs1_idx_q;
        rs2_idx_d   = rs2_idx_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        a_sel_pc_d  = a_sel_pc_q;
        b_sel_imm_d = b_sel_imm_q;
        alu_op_d    = alu_op_q;
        rd_idx_d    = rd_idx_q;
        reg_we_d    = reg_we_q;
        mem_read_d  = mem_read_q;
        if (!ex_stall) begin
            if (bubble) begin
                valid_d     = 1'b0;
                pc_d        = '0;
                rs1_idx_d   = '0;
                rs2_idx_d   = '0;
                rs1_data_d  = '0;
                rs2_data_d  = '0;
                imm_d       = '0;
                a_sel_pc_d  = 1'b0;
                b_sel_imm_d = 1'b0;
                alu_op_d    = ALU_ADD;
                rd_idx_d    = '0;
                reg_we_d    = 1'b0;
                mem_read_d  = 1'b0;
            end else begin
                valid_d     = 1'b1;
                pc_d        = id_pc;
                rs1_idx_d   = id_rs1_idx;
                rs2_idx_d   = id_rs2_idx;
                rs1_data_d  = cap_rs1;
                rs2_data_d  = cap_rs2;
                imm_d       = id_imm;
                a_sel_pc_d  = id_a_sel_pc;
                b_sel_imm_d = id_b_sel_imm;
                alu_op_d    = id_alu_op;
                rd_idx_d    = id_rd_idx;
                reg_we_d    = id_reg_we;
                mem_read_d  = id_mem_read;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_idx_q   <= '0;
            rs2_idx_q   <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            a_sel_pc_q  <= 1'b0;
            b_sel_imm_q <= 1'b0;
            alu_op_q    <= ALU_ADD;
            rd_idx_q    <= '0;
            reg_we_q    <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_idx_q   <= rs1_idx_d;
            rs2_idx_q   <= rs2_idx_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            a_sel_pc_q  <= a_sel_pc_d;
            b_sel_imm_q <= b_sel_imm_d;
            alu_op_q    <= alu_op_d;
            rd_idx_q    <= rd_idx_d;
            reg_we_q    <= reg_we_d;
            mem_read_q  <= mem_read_d;
        end
    end

    // MEM is younger than WB, so it wins; x0 is never a forwarding target.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (mem_reg_we && (mem_rd_idx != 5'd0) && (mem_rd_idx == rs1_idx_q)) begin
            fwd_rs1 = mem_fwd_data;
        end else if (wb_reg_we && (wb_rd_idx != 5'd0) && (wb_rd_idx == rs1_idx_q)) begin
            fwd_rs1 = wb_data;
        end
        fwd_rs2 = rs2_data_q;
        if (mem_reg_we && (mem_rd_idx != 5'd0) && (mem_rd_idx == rs2_idx_q)) begin
            fwd_rs2 = mem_fwd_data;
        end else if (wb_reg_we && (wb_rd_idx != 5'd0) && (wb_rd_idx == rs2_idx_q)) begin
            fwd_rs2 = wb_data;
        end
    end

    always_comb begin
        ex_valid      = valid_q;
        alu_a         = a_sel_pc_q ? pc_q : fwd_rs1;
        alu_b         = b_sel_imm_q ? imm_q : fwd_rs2;
        alu_op        = alu_op_q;
        ex_store_data = fwd_rs2;
        ex_pc         = pc_q;
        ex_rd_idx     = rd_idx_q;
        ex_reg_we     = valid_q && reg_we_q;
        ex_mem_read   = valid_q && mem_read_q;
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, forwarding priority, x0, load-use, capture bypass, stall vs flush.
module tb_ex_operand_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_idx;
    logic [4:0]  id_rs2_idx;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic        id_a_sel_pc;
    logic        id_b_sel_imm;
    logic [4:0]  id_alu_op;
    logic [4:0]  id_rd_idx;
    logic        id_reg_we;
    logic        id_mem_read;
    logic        flush;
    logic        ex_stall;
    logic [4:0]  mem_rd_idx;
    logic        mem_reg_we;
    logic [31:0] mem_fwd_data;
    logic [4:0]  wb_rd_idx;
    logic        wb_reg_we;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_op;
    logic [31:0] ex_store_data;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd_idx;
    logic        ex_reg_we;
    logic        ex_mem_read;

    int tests = 0;
    int fails = 0;

    ex_operand_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_a_sel_pc(id_a_sel_pc), .id_b_sel_imm(id_b_sel_imm),
        .id_alu_op(id_alu_op), .id_rd_idx(id_rd_idx), .id_reg_we(id_reg_we),
        .id_mem_read(id_mem_read), .flush(flush), .ex_stall(ex_stall),
        .mem_rd_idx(mem_rd_idx), .mem_reg_we(mem_reg_we), .mem_fwd_data(mem_fwd_data),
        .wb_rd_idx(wb_rd_idx), .wb_reg_we(wb_reg_we), .wb_data(wb_data),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd_idx(ex_rd_idx),
        .ex_reg_we(ex_reg_we), .ex_mem_read(ex_mem_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_pc = 0; id_rs1_idx = 0; id_rs2_idx = 0;
        id_rs1_used = 0; id_rs2_used = 0; id_rs1_data = 0; id_rs2_data = 0;
        id_imm = 0; id_a_sel_pc = 0; id_b_sel_imm = 0; id_alu_op = 0;
        id_rd_idx = 0; id_reg_we = 0; id_mem_read = 0; flush = 0; ex_stall = 0;
        mem_rd_idx = 0; mem_reg_we = 0; mem_fwd_data = 0;
        wb_rd_idx = 0; wb_reg_we = 0; wb_data = 0;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        #1;
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_alu_op",   {27'b0, alu_op},   32'd0);
        chk("rst_alu_a",    alu_a,             32'd0);
        chk("rst_alu_b",    alu_b,             32'd0);
        chk("rst_reg_we",   {31'b0, ex_reg_we}, 32'd0);
        chk("rst_id_ready", {31'b0, id_ready},  32'd1);
        tick();
        rst = 0;

        // Plain capture: rs1=5, rs2=6, no forwarding.
        id_valid = 1; id_pc = 32'h100; id_rs1_idx = 5; id_rs2_idx = 6;
        id_rs1_used = 1; id_rs2_used = 1; id_rs1_data = 32'hA; id_rs2_data = 32'hB;
        id_imm = 32'h40; id_alu_op = 5'd3; id_rd_idx = 9; id_reg_we = 1;
        tick();
        id_valid = 0;
        #1;
        chk("cap_ex_valid", {31'b0, ex_valid}, 32'd1);
        chk("cap_alu_a",    alu_a,             32'hA);
        chk("cap_alu_b",    alu_b,             32'hB);
        chk("cap_alu_op",   {27'b0, alu_op},   32'd3);
        chk("cap_ex_pc",    ex_pc,             32'h100);
        chk("cap_rd_idx",   {27'b0, ex_rd_idx}, 32'd9);
        chk("cap_reg_we",   {31'b0, ex_reg_we}, 32'd1);
        chk("cap_store",    ex_store_data,     32'hB);

        // Forward priority on rs1=5.
        mem_rd_idx = 5; mem_reg_we = 1; mem_fwd_data = 32'h11;
        wb_rd_idx = 5; wb_reg_we = 1; wb_data = 32'h22;
        #1;
        chk("fwd_mem_over_wb", alu_a, 32'h11);
        chk("fwd_rs2_untouched", alu_b, 32'hB);
        mem_reg_we = 0;
        #1;
        chk("fwd_wb", alu_a, 32'h22);

        // Asynchronous reset while EX is valid.
        clear_inputs();
        #1;
        chk("pre_rst_valid", {31'b0, ex_valid}, 32'd1);
        rst = 1;
        #1;
        chk("mid_rst_valid", {31'b0, ex_valid}, 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        chk("mid_rst_pc",    ex_pc, 32'd0);
        rst = 0;
        tick();

        // x0 is never forwarded.
        id_valid = 1; id_pc = 32'h200; id_rs1_idx = 0; id_rs1_used = 1;
        id_b_sel_imm = 1; id_imm = 32'h7; id_rd_idx = 2; id_reg_we = 1;
        tick();
        clear_inputs();
        mem_rd_idx = 0; mem_reg_we = 1; mem_fwd_data = 32'hFFFF;
        wb_rd_idx = 0; wb_reg_we = 1; wb_data = 32'h1234;
        #1;
        chk("x0_alu_a", alu_a, 32'd0);
        chk("x0_alu_b_imm", alu_b, 32'h7);
        clear_inputs();

        // Load-use: lw x3, 4(x1) then add x4, x3, x3.
        id_valid = 1; id_pc = 32'h300; id_rs1_idx = 1; id_rs1_used = 1;
        id_rs1_data = 32'h1000; id_b_sel_imm = 1; id_imm = 4;
        id_rd_idx = 3; id_reg_we = 1; id_mem_read = 1;
        tick();
        chk("lw_mem_read", {31'b0, ex_mem_read}, 32'd1);
        chk("lw_alu_a",    alu_a, 32'h1000);
        clear_inputs();
        id_valid = 1; id_pc = 32'h304; id_rs1_idx = 3; id_rs2_idx = 3;
        id_rd_idx = 4; id_reg_we = 1; id_alu_op = 5'd0;
        #1;
        chk("lu_unused_ready", {31'b0, id_ready}, 32'd1);
        id_rs1_used = 1; id_rs2_used = 1;
        #1;
        chk("lu_hz_ready", {31'b0, id_ready}, 32'd0);
        tick();
        chk("lu_bubble_valid",  {31'b0, ex_valid},    32'd0);
        chk("lu_bubble_we",     {31'b0, ex_reg_we},   32'd0);
        chk("lu_bubble_mread",  {31'b0, ex_mem_read}, 32'd0);
        chk("lu_bubble_op",     {27'b0, alu_op},      32'd0);
        chk("lu_ready_again",   {31'b0, id_ready},    32'd1);
        tick();
        id_valid = 0;
        mem_rd_idx = 3; mem_reg_we = 1; mem_fwd_data = 32'h5555;
        #1;
        chk("lu_add_valid", {31'b0, ex_valid}, 32'd1);
        chk("lu_add_rd",    {27'b0, ex_rd_idx}, 32'd4);
        chk("lu_add_a",     alu_a, 32'h5555);
        chk("lu_add_b",     alu_b, 32'h5555);
        clear_inputs();

        // Capture bypass: WB writes x7 in the same cycle ID reads it.
        id_valid = 1; id_pc = 32'h400; id_a_sel_pc = 1; id_rs2_idx = 7; id_rs2_used = 1;
        id_rs2_data = 32'h0; id_alu_op = 5'd5; id_rd_idx = 8; id_reg_we = 1;
        wb_rd_idx = 7; wb_reg_we = 1; wb_data = 32'hABCD;
        tick();
        clear_inputs();
        #1;
        chk("byp_alu_b", alu_b, 32'hABCD);
        chk("byp_store", ex_store_data, 32'hABCD);
        chk("byp_alu_a_pc", alu_a, 32'h400);

        // Stall with flush held: EX frozen, then bubble once the stall clears.
        id_valid = 1; id_pc = 32'h500; id_alu_op = 5'd7; id_rd_idx = 10; id_reg_we = 1;
        ex_stall = 1; flush = 1;
        #1;
        chk("stall_ready", {31'b0, id_ready}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_pc",    ex_pc, 32'h400);
            chk("stall_valid", {31'b0, ex_valid}, 32'd1);
            chk("stall_op",    {27'b0, alu_op}, 32'd5);
            chk("stall_b",     alu_b, 32'hABCD);
        end
        ex_stall = 0;
        tick();
        chk("flush_valid", {31'b0, ex_valid}, 32'd0);
        chk("flush_we",    {31'b0, ex_reg_we}, 32'd0);
        chk("flush_op",    {27'b0, alu_op}, 32'd0);
        flush = 0;
        tick();
        chk("after_flush_pc",    ex_pc, 32'h500);
        chk("after_flush_valid", {31'b0, ex_valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
